// File: rtl/id_imm_sequencer_if.sv
// Bundles the fetch-side, execute-side and sign-extender signals of the
// decode front end so the sequencer and its environment share one port.
interface id_imm_sequencer_if #(
  parameter int XLEN      = 32,
  parameter int ILL_CNT_W = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [XLEN-1:0]      in_instr;
  logic [XLEN-1:0]      in_pc;
  logic                 flush;
  logic [6:0]           ext_opcode;
  logic [19:0]          ext_imm_in;
  logic [XLEN-1:0]      ext_imm_out;
  logic                 out_valid;
  logic                 out_ready;
  logic [XLEN-1:0]      out_pc;
  logic [6:0]           out_opcode;
  logic [4:0]           out_rd;
  logic [4:0]           out_rs1;
  logic [4:0]           out_rs2;
  logic [2:0]           out_funct3;
  logic [6:0]           out_funct7;
  logic [XLEN-1:0]      out_imm;
  logic                 out_illegal;
  logic [ILL_CNT_W-1:0] ill_count;

  // Decode stage view: consumes fetch, flush, extender result and execute ready.
  modport slave (
    input  in_valid, in_instr, in_pc, flush, ext_imm_out, out_ready,
    output in_ready, ext_opcode, ext_imm_in, out_valid, out_pc, out_opcode,
           out_rd, out_rs1, out_rs2, out_funct3, out_funct7, out_imm,
           out_illegal, ill_count
  );

  // Environment view: fetch, execute and the sign extender around the stage.
  modport master (
    output in_valid, in_instr, in_pc, flush, ext_imm_out, out_ready,
    input  in_ready, ext_opcode, ext_imm_in, out_valid, out_pc, out_opcode,
           out_rd, out_rs1, out_rs2, out_funct3, out_funct7, out_imm,
           out_illegal, ill_count
  );
endinterface

// File: rtl/id_imm_sequencer.sv
// Decode-stage front end: splits fetched instructions into fields, packs the
// immediate for the external sign extender, captures its result and buffers
// decoded bundles in a 2-entry skid queue so in_ready never depends on out_ready.
module id_imm_sequencer #(
  parameter int XLEN      = 32,
  parameter int ILL_CNT_W = 8
) (
  input logic               clk,
  input logic               rst,
  id_imm_sequencer_if.slave bus
);

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [6:0]      opcode;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm;
    logic            illegal;
  } bundle_t;

  state_t               state;
  state_t               next_state;
  bundle_t              head;
  bundle_t              skid;
  bundle_t              incoming;
  logic [6:0]           opcode;
  logic [19:0]          packed_imm;
  logic                 legal;
  logic                 push;
  logic                 pop;
  logic                 load_head_in;
  logic                 load_head_skid;
  logic                 load_skid;
  logic [ILL_CNT_W-1:0] ill_q;

  assign opcode = bus.in_instr[6:0];

  // Rearranges the scattered immediate bits into the extender's 20-bit layout
  // and flags opcodes outside the supported set.
  always_comb begin
    packed_imm = '0;
    legal      = 1'b1;
    case (opcode)
      OP_IMM, OP_LOAD: packed_imm = {8'b0, bus.in_instr[31:20]};
      OP_JALR:         packed_imm = {{8{bus.in_instr[31]}}, bus.in_instr[31:20]};
      OP_STORE:        packed_imm = {8'b0, bus.in_instr[31:25], bus.in_instr[11:7]};
      OP_BRANCH:       packed_imm = {8'b0, bus.in_instr[31], bus.in_instr[7],
                                     bus.in_instr[30:25], bus.in_instr[11:8]};
      OP_LUI, OP_AUIPC: packed_imm = bus.in_instr[31:12];
      OP_JAL:          packed_imm = {bus.in_instr[31], bus.in_instr[19:12],
                                     bus.in_instr[20], bus.in_instr[30:21]};
      OP_REG:          packed_imm = '0;
      default:         legal      = 1'b0;
    endcase
  end

  // Builds the bundle that would be stored if fetch transfers this cycle;
  // illegal opcodes carry a zero immediate regardless of the extender.
  always_comb begin
    incoming         = '0;
    incoming.pc      = bus.in_pc;
    incoming.opcode  = opcode;
    incoming.rd      = bus.in_instr[11:7];
    incoming.rs1     = bus.in_instr[19:15];
    incoming.rs2     = bus.in_instr[24:20];
    incoming.funct3  = bus.in_instr[14:12];
    incoming.funct7  = bus.in_instr[31:25];
    incoming.imm     = legal ? bus.ext_imm_out : '0;
    incoming.illegal = !legal;
  end

  assign bus.ext_opcode = opcode;
  assign bus.ext_imm_in = packed_imm;

  assign bus.in_ready  = !rst && (state != TWO) && !bus.flush;
  assign bus.out_valid = (state != EMPTY);
  assign push          = bus.in_valid && bus.in_ready;
  assign pop           = bus.out_valid && bus.out_ready;

  // Queue occupancy control: decides the next fill level and which storage
  // slot each accepted or promoted bundle lands in; flush empties the queue.
  always_comb begin
    next_state     = state;
    load_head_in   = 1'b0;
    load_head_skid = 1'b0;
    load_skid      = 1'b0;
    case (state)
      EMPTY: begin
        if (push) begin
          next_state   = ONE;
          load_head_in = 1'b1;
        end
      end
      ONE: begin
        if (push && pop) begin
          load_head_in = 1'b1;
        end else if (push) begin
          next_state = TWO;
          load_skid  = 1'b1;
        end else if (pop) begin
          next_state = EMPTY;
        end
      end
      TWO: begin
        if (pop) begin
          next_state     = ONE;
          load_head_skid = 1'b1;
        end
      end
      default: next_state = EMPTY;
    endcase
    if (bus.flush) begin
      next_state = EMPTY;
    end
  end

  // Occupancy register; reset drops every buffered bundle immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= EMPTY;
    end else begin
      state <= next_state;
    end
  end

  // Head/skid storage: head feeds execute, skid absorbs the second entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head <= '0;
      skid <= '0;
    end else begin
      if (load_head_in) begin
        head <= incoming;
      end else if (load_head_skid) begin
        head <= skid;
      end
      if (load_skid) begin
        skid <= incoming;
      end
    end
  end

  // Saturating tally of accepted illegal instructions, untouched by flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ill_q <= '0;
    end else if (push && !legal && (ill_q != '1)) begin
      ill_q <= ill_q + ILL_CNT_W'(1);
    end
  end

  assign bus.ill_count   = ill_q;
  assign bus.out_pc      = head.pc;
  assign bus.out_opcode  = head.opcode;
  assign bus.out_rd      = head.rd;
  assign bus.out_rs1     = head.rs1;
  assign bus.out_rs2     = head.rs2;
  assign bus.out_funct3  = head.funct3;
  assign bus.out_funct7  = head.funct7;
  assign bus.out_imm     = head.imm;
  assign bus.out_illegal = head.illegal;

endmodule

// File: doc/id_imm_sequencer.md
Name: id_imm_sequencer

Overview:
- Decode-stage front end between fetch and execute.
- Accepts fetched instructions over a valid/ready handshake and splits out the opcode, register indices and function fields.
- Packs the immediate bits into the 20-bit field layout the immediate sign extender expects, drives the extender, and captures its 32-bit result.
- Buffers decoded bundles in a 2-entry skid queue so that fetch-side ready never depends combinationally on execute-side ready.

Parameters:
- XLEN, 32, instruction/PC/immediate width.
- ILL_CNT_W, 8, width of the saturating illegal-opcode counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  block can accept; a transfer occurs when in_valid&&in_ready.
- in_instr  in  32  instruction word.
- in_pc  in  32  instruction PC.
- flush  in  1  synchronous pipeline flush (branch redirect).
- ext_opcode  out  7  opcode to the sign extender (combinational from in_instr).
- ext_imm_in  out  20  packed immediate to the sign extender (combinational).
- ext_imm_out  in  32  sign-extended immediate returned combinationally by the extender.
- out_valid  out  1  head bundle valid.
- out_ready  in  1  execute accepts; a transfer occurs when out_valid&&out_ready.
- out_pc  out  32  bundle PC.
- out_opcode  out  7  bundle opcode.
- out_rd, out_rs1, out_rs2  out  5 each  register indices (instr[11:7], [19:15], [24:20]).
- out_funct3  out  3  instr[14:12].
- out_funct7  out  7  instr[31:25].
- out_imm  out  32  captured immediate.
- out_illegal  out  1  opcode not supported.
- ill_count  out  ILL_CNT_W  saturating count of accepted illegal instructions.

Behaviour:
- Reset (async, rst=1): queue EMPTY, out_valid=0, in_ready=0 while rst is asserted, in_ready=1 the first cycle after release, ill_count=0, all out_* data=0.
- Packing of ext_imm_in (s=in_instr[31]) by opcode:
  - 0010011 and 0000011: {8'b0, instr[31:20]}.
  - 1100111 (jalr): {{8{s}}, instr[31:20]}.
  - 0100011: {8'b0, instr[31:25], instr[11:7]}.
  - 1100011: {8'b0, instr[31], instr[7], instr[30:25], instr[11:8]}.
  - 0110111 and 0010111: instr[31:12].
  - 1101111: {instr[31], instr[19:12], instr[20], instr[30:21]}.
  - 0110011 and any other opcode: 20'b0.
- ext_opcode = in_instr[6:0] at all times.
- Legal set: the nine opcodes listed above. For any other opcode, illegal=1 and the captured imm is forced to 0; ext_imm_out is ignored.
- Captured imm for legal opcodes is ext_imm_out, sampled in the acceptance cycle.
- Queue FSM:
  - States: EMPTY (0 entries), ONE (1), TWO (2).
  - in_ready = (state != TWO) && !flush.
  - Transitions:
    - EMPTY + push → ONE.
    - ONE + push & !pop → TWO.
    - ONE + pop & !push → EMPTY.
    - ONE + push & pop → ONE, with the new entry becoming the head.
    - TWO + pop → ONE, with the skid entry promoted to head.
    - Push in TWO is impossible because in_ready=0.
  - Order is strictly FIFO.
- Latency: 1 cycle from acceptance to out_valid. Sustained throughput is 1 instruction/cycle when out_ready=1.
- Output data stays stable while out_valid && !out_ready.
- Flush:
  - Next state EMPTY, out_valid=0 next cycle.
  - Any input presented in the flush cycle is dropped (in_ready=0).
  - An output transfer in the flush cycle still completes.
  - ill_count is not affected by flush.
- ill_count increments by 1 on each accepted illegal instruction and saturates at all-ones; it is cleared only by rst.
- rst asserted mid-stream discards all entries immediately (asynchronously); nothing is replayed.

Test Plan:
- Reset then stream with out_ready=1:
  - Stimulus: addi x1,x0,-1 (0xFFF00093), pc 0x100; extender model returns 0xFFFFFFFF.
  - Required: ext_imm_in=0x00FFF. Next cycle out_valid=1, out_rd=1, out_imm=0xFFFFFFFF, out_illegal=0.
- Backpressure:
  - Stimulus: out_ready=0, push three back-to-back instructions (pc 0x0, 0x4, 0x8).
  - Required: in_ready drops after 2 accepts. The third is held by fetch. After out_ready=1, outputs appear in order 0x0, 0x4, 0x8 with no loss or duplication.
- Packing:
  - lui x5,0x12345 (0x123452B7) → ext_imm_in=0x12345.
  - jal with imm=-4 (0xFFDFF06F) → ext_imm_in=0xFFFFE.
  - sw imm=8 (0x00812423) → ext_imm_in=0x00008.
- Illegal:
  - Stimulus: opcode 0x7F, extender returns 0xDEADBEEF.
  - Required: out_illegal=1, out_imm=0, ill_count=1. With ILL_CNT_W=2, five illegal instructions leave ill_count=3.
- Flush:
  - Stimulus: queue in TWO, assert flush with in_valid=1.
  - Required: in_ready=0 that cycle, and the next cycle out_valid=0. The following instruction is accepted and emerges 1 cycle later.
- Async reset:
  - Stimulus: assert rst between clock edges while in TWO.
  - Required: out_valid=0 and ill_count=0 immediately, without waiting for a clock edge.
